instr_decode_ctrl: RTL

- Decode/control stage that sits directly downstream of instruction_memory_pc.
- Latches the 24-bit `instr` into an IF/ID register.
- Decodes the latched instruction and reads/writes a 16x8 register file.
- Resolves jumps and branches, driving `PCSrc` and `immediate` back to the fetch block.
- Small FSM handles branch flush and HALT (`instr` 0x700007).

---
 rtl/instr_decode_ctrl_if.sv | 22 ++
 rtl/instr_decode_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/instr_decode_ctrl_if.sv
// Fetch <-> decode bundle: instruction word in, branch/write-back/status out.
// master = fetch side (drives instr), slave = decode stage.
interface instr_decode_ctrl_if;
    logic [23:0] instr;
    logic        PCSrc;
    logic [7:0]  immediate;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        halted;
    logic        illegal;

    modport master (
        output instr,
        input  PCSrc, immediate, wb_en, wb_addr, wb_data, halted, illegal
    );

    modport slave (
        input  instr,
        output PCSrc, immediate, wb_en, wb_addr, wb_data, halted, illegal
    );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Decode/control stage: IF/ID register, 16x8 regfile, branch resolve, HALT.
// Ports: CLK, reset (async, active high), bus (slave: instr in;
// PCSrc/immediate to fetch, wb_en/wb_addr/wb_data, halted, illegal out).
// Optional macro ILLEGAL_TRAP_EN: opcodes 8-F set sticky illegal and halt.
module instr_decode_ctrl #(
    parameter int         NUM_REGS = 16,
    parameter logic [3:0] OPC_HALT = 4'h7
) (
    input logic CLK,
    input logic reset,
    instr_decode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

    state_t      state;
    logic [23:0] ir;
    logic        ir_valid;
    logic [7:0]  regs [NUM_REGS];

    logic [3:0]  opc, rd, rs1, rs2;
    logic [7:0]  imm, a, b, res;
    logic        live, wr, take, stop, trap, wen;

    assign opc = ir[23:20];
    assign rd  = ir[19:16];
    assign rs1 = ir[15:12];
    assign rs2 = ir[11:8];
    assign imm = ir[7:0];

    // R0 is hardwired to zero on the read side.
    assign a = (rs1 == 4'd0) ? 8'd0 : regs[rs1];
    assign b = (rs2 == 4'd0) ? 8'd0 : regs[rs2];

    assign live = ir_valid && (state == RUN);

    always_comb begin
        res  = 8'd0;
        wr   = 1'b0;
        take = 1'b0;
        stop = 1'b0;
        trap = 1'b0;
        if (live) begin
            unique case (1'b1)
                (opc == 4'h1): begin res = a + b;  wr = 1'b1; end
                (opc == 4'h2): begin res = a - b;  wr = 1'b1; end
                (opc == 4'h3): begin res = imm;    wr = 1'b1; end
                (opc == 4'h4): begin res = a + imm; wr = 1'b1; end
                (opc == 4'h5): take = (a == b);
                (opc == 4'h6): take = 1'b1;
                (opc == OPC_HALT): stop = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                opc[3]: trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign wen = wr && (rd != 4'd0);

    assign bus.wb_en     = wen;
    assign bus.wb_addr   = wen ? rd : 4'd0;
    assign bus.wb_data   = wen ? res : 8'd0;
    assign bus.PCSrc     = take;
    assign bus.immediate = live ? imm : 8'd0;
    assign bus.halted    = (state == HALTED);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
        end else if (wen) begin
            regs[rd] <= res;
        end
    end

    // The instruction fetched in the same edge as a taken branch is on
    // the wrong path, so it is latched but marked invalid (FLUSH).
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            ir       <= 24'd0;
            ir_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (stop || trap) begin
                        state    <= HALTED;
                        ir_valid <= 1'b0;
                    end else if (take) begin
                        state    <= FLUSH;
                        ir       <= bus.instr;
                        ir_valid <= 1'b0;
                    end else begin
                        ir       <= bus.instr;
                        ir_valid <= 1'b1;
                    end
                end
                FLUSH: begin
                    state    <= RUN;
                    ir       <= bus.instr;
                    ir_valid <= 1'b1;
                end
                HALTED: ir_valid <= 1'b0;
                default: begin
                    state    <= RUN;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic ill_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)     ill_q <= 1'b0;
        else if (trap) ill_q <= 1'b1;
    end

    assign bus.illegal = ill_q;
`else
    assign bus.illegal = 1'b0;
`endif

endmodule
